// File: rtl/pmc_dump_unit.sv
// Snapshots four 32-bit PMC counters and streams them as a byte frame over a valid/ready link.
// Define PMC_DUMP_CHECKSUM_EN to append an XOR checksum byte (18-byte frame instead of 17).
module pmc_dump_unit #(
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        snap_req,
  input  logic [31:0] stall_count,
  input  logic [31:0] instr_cycle_count,
  input  logic [31:0] arith_count,
  input  logic [31:0] mem_access_count,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        dump_done,
  output logic [15:0] dump_count
);

`ifdef PMC_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} state_e;
`else
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_e;
`endif

  state_e             state_q, state_d;
  logic [15:0][7:0]   shadow_q, shadow_d;
  logic [3:0]         idx_q, idx_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               dump_done_q, dump_done_d;
  logic [15:0]        dump_count_q, dump_count_d;
  logic               xfer;
`ifdef PMC_DUMP_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  assign xfer = tx_valid_q & tx_ready;

  // NOTE: every *_d gets a default first, so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    idx_d        = idx_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = busy_q;
    dump_done_d  = 1'b0;
    dump_count_d = dump_count_q;
`ifdef PMC_DUMP_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (snap_req) begin
          // Shadow is loaded only here, so live counter changes never reach a frame in flight.
          shadow_d   = {stall_count, instr_cycle_count, arith_count, mem_access_count};
          idx_d      = 4'd0;
          tx_data_d  = HEADER_BYTE;
          tx_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = HEADER;
`ifdef PMC_DUMP_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end

      HEADER: begin
        if (xfer) begin
          tx_data_d = shadow_q[15];
          state_d   = PAYLOAD;
`ifdef PMC_DUMP_CHECKSUM_EN
          csum_d    = csum_q ^ tx_data_q;
`endif
        end
      end

      PAYLOAD: begin
        if (xfer) begin
`ifdef PMC_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ tx_data_q;
`endif
          if (idx_q == 4'd15) begin
`ifdef PMC_DUMP_CHECKSUM_EN
            tx_data_d = csum_q ^ tx_data_q;
            state_d   = CHECKSUM;
`else
            tx_data_d    = 8'h00;
            tx_valid_d   = 1'b0;
            busy_d       = 1'b0;
            dump_done_d  = 1'b1;
            dump_count_d = dump_count_q + 16'd1;
            state_d      = IDLE;
`endif
          end else begin
            // Byte 0 of the shadow index space is the MSB of stall_count.
            idx_d     = idx_q + 4'd1;
            tx_data_d = shadow_q[4'd14 - idx_q];
          end
        end
      end

`ifdef PMC_DUMP_CHECKSUM_EN
      CHECKSUM: begin
        if (xfer) begin
          tx_data_d    = 8'h00;
          tx_valid_d   = 1'b0;
          busy_d       = 1'b0;
          dump_done_d  = 1'b1;
          dump_count_d = dump_count_q + 16'd1;
          state_d      = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      // NOTE: the 128-bit shadow is an ordinary register, not a memory, so it is cleared on reset like any flop.
      shadow_q     <= '0;
      idx_q        <= 4'd0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      dump_done_q  <= 1'b0;
      dump_count_q <= 16'h0000;
`ifdef PMC_DUMP_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      idx_q        <= idx_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      dump_done_q  <= dump_done_d;
      dump_count_q <= dump_count_d;
`ifdef PMC_DUMP_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign dump_done  = dump_done_q;
  assign dump_count = dump_count_q;

endmodule

// File: tb/tb_pmc_dump_unit.sv
// Bench for pmc_dump_unit: frames are compared against a queue built from the snapshot values.
// Honours PMC_DUMP_CHECKSUM_EN the same way as the design (18-byte frames when defined).
module tb_pmc_dump_unit;

`ifdef PMC_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam logic [7:0] HDR = 8'hA5;

  logic        clk;
  logic        reset;
  logic        snap_req;
  logic [31:0] stall_count, instr_cycle_count, arith_count, mem_access_count;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        dump_done;
  logic [15:0] dump_count;

  int          checks;
  int          errors;
  logic [15:0] exp_count;

  pmc_dump_unit #(.HEADER_BYTE(HDR)) dut (
    .clk               (clk),
    .reset             (reset),
    .snap_req          (snap_req),
    .stall_count       (stall_count),
    .instr_cycle_count (instr_cycle_count),
    .arith_count       (arith_count),
    .mem_access_count  (mem_access_count),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .busy              (busy),
    .dump_done         (dump_done),
    .dump_count        (dump_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where dump_done is visible.
  // rmode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready.
  task automatic do_dump(input logic [31:0] c0, input logic [31:0] c1,
                         input logic [31:0] c2, input logic [31:0] c3,
                         input int rmode, input bit hold, input bit perturb,
                         input int abort_at);
    logic [7:0]  expq[$];
    logic [7:0]  got[$];
    logic [31:0] cnt[4];
    logic [7:0]  x, bv, prev_data;
    bit          prev_stall;
    int          n;

    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    stall_count       = c0;
    instr_cycle_count = c1;
    arith_count       = c2;
    mem_access_count  = c3;
    snap_req          = 1'b1;

    expq.push_back(HDR);
    x = HDR;
    for (int k = 0; k < 4; k++) begin
      for (int b = 3; b >= 0; b--) begin
        bv = 8'(cnt[k] >> (8 * b));
        expq.push_back(bv);
        x = x ^ bv;
      end
    end
    if (CSUM) expq.push_back(x);

    prev_stall = 1'b0;
    prev_data  = 8'h00;
    n          = 0;
    while (got.size() < expq.size() && n < 400) begin
      @(negedge clk);
      if (n == 0) begin
        check("latency_valid", 32'(tx_valid), 32'd1);
        check("latency_busy", 32'(busy), 32'd1);
      end
      snap_req = hold ? 1'b1 : (perturb ? 1'($urandom_range(0, 1)) : 1'b0);
      if (perturb) begin
        stall_count       = $urandom;
        instr_cycle_count = $urandom;
        arith_count       = $urandom;
        mem_access_count  = $urandom;
      end
      if (abort_at > 0 && got.size() == abort_at) begin
        reset    = 1'b0;
        snap_req = 1'b0;
        #1;
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(dump_done), 32'd0);
        check("rst_count", 32'(dump_count), 32'd0);
        exp_count = 16'h0000;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(tx_valid), 32'd1);
        check("stall_data", 32'(tx_data), 32'(prev_data));
      end
      check("in_frame", 32'({busy, dump_done}), 32'h2);
      case (rmode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (n % 4 == 0) || (n % 4 == 3);
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (tx_valid && tx_ready) got.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      n++;
    end

    check("frame_len", 32'(got.size()), 32'(expq.size()));
    if (rmode == 0) check("frame_cycles", 32'(n), 32'(expq.size()));
    @(negedge clk);
    snap_req  = hold;
    exp_count = exp_count + 16'd1;
    check("done_pulse", 32'({dump_done, busy, tx_valid}), 32'h4);
    check("dump_count", 32'(dump_count), 32'(exp_count));
    for (int k = 0; k < got.size() && k < expq.size(); k++)
      check($sformatf("byte%0d", k), 32'(got[k]), 32'(expq[k]));
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    exp_count         = 16'h0000;
    reset             = 1'b0;
    snap_req          = 1'b0;
    tx_ready          = 1'b0;
    stall_count       = 32'h0;
    instr_cycle_count = 32'h0;
    arith_count       = 32'h0;
    mem_access_count  = 32'h0;

    repeat (2) @(negedge clk);
    check("reset_valid", 32'(tx_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(dump_done), 32'd0);
    check("reset_count", 32'(dump_count), 32'd0);
    check("reset_data", 32'(tx_data), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Reference counters, ready held high (checksum byte 0xBE when enabled).
    do_dump(32'h3, 32'h10, 32'hC, 32'h4, 0, 1'b0, 1'b0, 0);
    check("done_one_cycle", 32'(dump_done), 32'd1);
    @(negedge clk);
    check("done_cleared", 32'(dump_done), 32'd0);

    // Ready pattern 1,0,0,1 through the payload.
    do_dump($urandom, $urandom, $urandom, $urandom, 1, 1'b0, 1'b0, 0);

    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      do_dump($urandom, $urandom, $urandom, $urandom, 2, 1'b0, 1'b0, 0);
    end

    // Counters and snap_req churn mid-dump; only one frame may result.
    @(negedge clk);
    do_dump($urandom, $urandom, $urandom, $urandom, 2, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("no_extra_frame", 32'({busy, tx_valid}), 32'd0);
    check("count_after_churn", 32'(dump_count), 32'(exp_count));

    // Reset after six bytes, then a clean frame from the header.
    do_dump($urandom, $urandom, $urandom, $urandom, 0, 1'b0, 1'b0, 6);
    @(negedge clk);
    check("post_rst_idle", 32'({busy, tx_valid}), 32'd0);
    do_dump(32'h3, 32'h10, 32'hC, 32'h4, 0, 1'b0, 1'b0, 0);
    snap_req = 1'b0;

    // Preload the frame counter near the top, then back-to-back frames with snap_req held.
    @(negedge clk);
    force dut.dump_count_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.dump_count_q;
    #1;
    check("preload", 32'(dump_count), 32'hFFFE);
    exp_count = 16'hFFFE;
    do_dump($urandom, $urandom, $urandom, $urandom, 0, 1'b1, 1'b0, 0);
    do_dump($urandom, $urandom, $urandom, $urandom, 2, 1'b1, 1'b0, 0);
    snap_req = 1'b0;
    check("wrap", 32'(dump_count), 32'h0000);
    @(negedge clk);
    check("wrap_idle", 32'({busy, tx_valid}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
